// File: rtl/us_scan_scheduler.sv
// -----------------------------------------------------------------------------
// us_scan_scheduler
//
// Time-multiplexes the three ultrasonic ranging channels (0 = right, 1 = left,
// 2 = middle) so that only one channel is ranging at any time. Each channel
// gets a fixed slot of SLOT_CYCLES clocks. A slot opens with a TRIG_CYCLES-wide
// start pulse. The first rising edge of that channel's meas_end after the pulse
// captures the scaled distance. If the slot closes without a capture, the
// distance is forced to 255 and the channel's timeout flag is raised.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       1 = keep scanning; 0 = finish the current slot, then idle
//   sensor_mask  per-channel enable, bit0 = R, bit1 = L, bit2 = M
//   meas_end     end-of-measurement level per channel (clk-synchronous)
//   raw_r/l/m    raw echo counts from the measurement units
//   start        one-hot start pulse to the measurement units
//   dist_r/l/m   captured 8-bit distances
//   dist_vld     one-cycle strobe per channel when its distance updates
//   timeout      per channel: the last slot ended without a measurement
//   busy         a slot is in progress
//   cur_ch       channel owning the current slot, 3 when idle
// -----------------------------------------------------------------------------
module us_scan_scheduler #(
  parameter int SLOT_CYCLES = 3000500,
  parameter int TRIG_CYCLES = 500,
  parameter int RAW_W       = 20,
  parameter int DIST_SHIFT  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       sensor_mask,
  input  logic [2:0]       meas_end,
  input  logic [RAW_W-1:0] raw_r,
  input  logic [RAW_W-1:0] raw_l,
  input  logic [RAW_W-1:0] raw_m,
  output logic [2:0]       start,
  output logic [7:0]       dist_r,
  output logic [7:0]       dist_l,
  output logic [7:0]       dist_m,
  output logic [2:0]       dist_vld,
  output logic [2:0]       timeout,
  output logic             busy,
  output logic [1:0]       cur_ch
);

  localparam int               CNT_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [1:0]       CH_NONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       ch_next;
  logic [1:0]       last_ch, last_next;
  logic             captured, captured_next;
  logic [2:0]       meas_q;

  logic [2:0]       cur_onehot;
  logic [2:0]       rise;
  logic             accept;
  logic             slot_end;
  logic             miss;
  logic [RAW_W-1:0] raw_sel;
  logic [RAW_W-1:0] raw_shift;
  logic [7:0]       cap_dist;

  // Next enabled channel after 'from' in rotation 0 -> 1 -> 2 -> 0. Falls back
  // to 'from' itself, which gives the repeat behaviour for a single-bit mask.
  function automatic logic [1:0] next_set(input logic [1:0] from,
                                          input logic [2:0] mask);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = (from == 2'd2) ? 2'd0 : from + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (mask[c1])      return c1;
    else if (mask[c2]) return c2;
    else               return from;
  endfunction

  // ---------------------------------------------------------------------------
  // Decode and capture datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    cur_onehot = 3'b000;
    raw_sel    = '0;
    case (cur_ch)
      2'd0:    begin cur_onehot = 3'b001; raw_sel = raw_r; end
      2'd1:    begin cur_onehot = 3'b010; raw_sel = raw_l; end
      2'd2:    begin cur_onehot = 3'b100; raw_sel = raw_m; end
      default: begin cur_onehot = 3'b000; raw_sel = '0;    end
    endcase

    rise      = meas_end & ~meas_q;
    raw_shift = raw_sel >> DIST_SHIFT;
    cap_dist  = (raw_shift > RAW_W'(255)) ? 8'hFF : raw_shift[7:0];

    // Only the slot owner's first edge after the start pulse counts.
    accept   = (state == S_WAIT) && !captured && |(rise & cur_onehot);
    slot_end = (state == S_WAIT) && (cnt == SLOT_LAST);
    // An edge landing on the very last slot cycle still counts as a capture.
    miss     = slot_end && !captured && !accept;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    ch_next       = cur_ch;
    last_next     = last_ch;
    captured_next = captured | accept;

    case (state)
      S_IDLE: begin
        cnt_next      = '0;
        captured_next = 1'b0;
        if (enable && (sensor_mask != 3'b000)) begin
          state_next = S_TRIG;
          ch_next    = next_set(last_ch, sensor_mask);
        end
      end

      S_TRIG: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == TRIG_LAST) state_next = S_WAIT;
      end

      S_WAIT: begin
        cnt_next = cnt + CNT_W'(1);
        if (slot_end) begin
          // enable and mask are only looked at here and in IDLE, so a
          // mid-slot change never shortens the slot.
          last_next     = cur_ch;
          cnt_next      = '0;
          captured_next = 1'b0;
          if (enable && (sensor_mask != 3'b000)) begin
            state_next = S_TRIG;
            ch_next    = next_set(cur_ch, sensor_mask);
          end else begin
            state_next = S_IDLE;
            ch_next    = CH_NONE;
          end
        end
      end

      default: begin
        state_next    = S_IDLE;
        cnt_next      = '0;
        ch_next       = CH_NONE;
        captured_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_ch   <= CH_NONE;
      // Resuming "after channel 2" selects the lowest set mask bit, which is
      // exactly the required behaviour for the first scan after reset.
      last_ch  <= 2'd2;
      captured <= 1'b0;
      meas_q   <= 3'b000;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      cur_ch   <= ch_next;
      last_ch  <= last_next;
      captured <= captured_next;
      meas_q   <= meas_end;
    end
  end

  // ---------------------------------------------------------------------------
  // Published distances, strobes and timeout flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_r   <= 8'd0;
      dist_l   <= 8'd0;
      dist_m   <= 8'd0;
      dist_vld <= 3'b000;
      timeout  <= 3'b000;
    end else begin
      dist_vld <= 3'b000;
      if (accept || miss) begin
        dist_vld <= cur_onehot;
        if (cur_onehot[0]) dist_r <= accept ? cap_dist : 8'hFF;
        if (cur_onehot[1]) dist_l <= accept ? cap_dist : 8'hFF;
        if (cur_onehot[2]) dist_m <= accept ? cap_dist : 8'hFF;
        timeout <= accept ? (timeout & ~cur_onehot) : (timeout | cur_onehot);
      end
    end
  end

  // Derived directly from registered state so reset clears them at once.
  assign start = (state == S_TRIG) ? cur_onehot : 3'b000;
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_us_scan_scheduler.sv
// -----------------------------------------------------------------------------
// tb_us_scan_scheduler
//
// Bench for us_scan_scheduler with short slots (SLOT = 100, TRIG = 5). A
// slot-level reference model tracks which channel owns the slot and the
// position inside it, and applies the ranging rules: first meas_end rise after
// the start pulse wins, raw / 2^DIST_SHIFT clipped at 255, otherwise 255 plus
// timeout at slot end. Each cycle, step() compares every output against the
// model, then advances the model and the clock. The scenario tasks add explicit
// checks against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_us_scan_scheduler;

  localparam int SLOT  = 100;
  localparam int TRIG  = 5;
  localparam int RAW_W = 20;
  localparam int SHIFT = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic [2:0]       sensor_mask = 3'b000;
  logic [2:0]       meas_end = 3'b000;
  logic [RAW_W-1:0] raw_r = '0;
  logic [RAW_W-1:0] raw_l = '0;
  logic [RAW_W-1:0] raw_m = '0;
  logic [2:0]       start;
  logic [7:0]       dist_r, dist_l, dist_m;
  logic [2:0]       dist_vld;
  logic [2:0]       timeout;
  logic             busy;
  logic [1:0]       cur_ch;

  us_scan_scheduler #(
    .SLOT_CYCLES(SLOT),
    .TRIG_CYCLES(TRIG),
    .RAW_W      (RAW_W),
    .DIST_SHIFT (SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sensor_mask(sensor_mask),
    .meas_end   (meas_end),
    .raw_r      (raw_r),
    .raw_l      (raw_l),
    .raw_m      (raw_m),
    .start      (start),
    .dist_r     (dist_r),
    .dist_l     (dist_l),
    .dist_m     (dist_m),
    .dist_vld   (dist_vld),
    .timeout    (timeout),
    .busy       (busy),
    .cur_ch     (cur_ch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  bit         m_active;   // a slot is running
  bit         m_fresh;    // no slot has completed since reset
  bit         m_cap;      // current slot already captured
  int         m_ch;       // slot owner
  int         m_pos;      // cycle index inside the slot
  int         m_last;     // owner of the last completed slot
  logic [7:0] m_dist[3];
  logic [2:0] m_to;
  logic [2:0] m_vld;
  logic [2:0] m_prev;     // meas_end as driven on the previous cycle

  function automatic logic [2:0] bit_of(input int ch);
    return 3'(1 << ch);
  endfunction

  function automatic int lowest(input logic [2:0] mask);
    for (int k = 0; k < 3; k++) if (mask[k]) return k;
    return 0;
  endfunction

  function automatic int next_after(input int from, input logic [2:0] mask);
    for (int k = 1; k <= 3; k++) if (mask[(from + k) % 3]) return (from + k) % 3;
    return from;
  endfunction

  function automatic logic [7:0] ref_dist(input logic [RAW_W-1:0] raw);
    int q;
    q = int'(raw) / (1 << SHIFT);
    return (q > 255) ? 8'd255 : 8'(q);
  endfunction

  function automatic logic [RAW_W-1:0] raw_of(input int ch);
    if (ch == 0) return raw_r;
    if (ch == 1) return raw_l;
    return raw_m;
  endfunction

  function automatic logic [7:0] dist_out(input int ch);
    if (ch == 0) return dist_r;
    if (ch == 1) return dist_l;
    return dist_m;
  endfunction

  // Compare all outputs with the model, then advance model and clock by one.
  task automatic step();
    logic [2:0] exp_start;
    logic [1:0] exp_cur;
    logic [2:0] rise;
    exp_start = (m_active && m_pos < TRIG) ? bit_of(m_ch) : 3'b000;
    exp_cur   = m_active ? 2'(m_ch) : 2'd3;

    total++; if (start !== exp_start) begin bad++; $display("FAIL start cyc=%0d got=%b want=%b", cyc, start, exp_start); end
    total++; if (busy !== m_active) begin bad++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, m_active); end
    total++; if (cur_ch !== exp_cur) begin bad++; $display("FAIL cur_ch cyc=%0d got=%0d want=%0d", cyc, cur_ch, exp_cur); end
    total++; if (dist_vld !== m_vld) begin bad++; $display("FAIL dist_vld cyc=%0d got=%b want=%b", cyc, dist_vld, m_vld); end
    total++; if (timeout !== m_to) begin bad++; $display("FAIL timeout cyc=%0d got=%b want=%b", cyc, timeout, m_to); end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (dist_out(c) !== m_dist[c]) begin
        bad++; $display("FAIL dist[%0d] cyc=%0d got=%0d want=%0d", c, cyc, dist_out(c), m_dist[c]);
      end
    end

    m_vld = 3'b000;
    rise  = meas_end & ~m_prev;
    if (m_active) begin
      if (m_pos >= TRIG && !m_cap && rise[m_ch]) begin
        m_cap        = 1'b1;
        m_dist[m_ch] = ref_dist(raw_of(m_ch));
        m_vld        = bit_of(m_ch);
        m_to[m_ch]   = 1'b0;
      end
      if (m_pos == SLOT - 1) begin
        if (!m_cap) begin
          m_dist[m_ch] = 8'd255;
          m_vld        = bit_of(m_ch);
          m_to[m_ch]   = 1'b1;
        end
        m_last  = m_ch;
        m_fresh = 1'b0;
        if (enable && sensor_mask != 3'b000) begin
          m_ch  = next_after(m_ch, sensor_mask);
          m_pos = 0;
          m_cap = 1'b0;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_pos++;
      end
    end else if (enable && sensor_mask != 3'b000) begin
      m_active = 1'b1;
      m_ch     = m_fresh ? lowest(sensor_mask) : next_after(m_last, sensor_mask);
      m_pos    = 0;
      m_cap    = 1'b0;
    end
    m_prev = meas_end;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    meas_end = 3'b000;
    #1;
    total++; if (start !== 3'b000) begin bad++; $display("FAIL rst_start got=%b want=000", start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (cur_ch !== 2'd3) begin bad++; $display("FAIL rst_cur_ch got=%0d want=3", cur_ch); end
    total++; if (dist_vld !== 3'b000) begin bad++; $display("FAIL rst_vld got=%b want=000", dist_vld); end
    total++; if (timeout !== 3'b000) begin bad++; $display("FAIL rst_timeout got=%b want=000", timeout); end
    total++; if ({dist_r, dist_l, dist_m} !== 24'd0) begin bad++; $display("FAIL rst_dist got=%0d/%0d/%0d want=0/0/0", dist_r, dist_l, dist_m); end
    m_active = 1'b0;
    m_fresh  = 1'b1;
    m_cap    = 1'b0;
    m_ch     = 0;
    m_pos    = 0;
    m_last   = 0;
    m_to     = 3'b000;
    m_vld    = 3'b000;
    m_prev   = 3'b000;
    for (int c = 0; c < 3; c++) m_dist[c] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Pulse on the slot owner's meas_end from position 'at' for 20 cycles.
  function automatic logic [2:0] owner_pulse(input int at);
    return (m_active && m_pos >= at && m_pos < at + 20) ? bit_of(m_ch) : 3'b000;
  endfunction

  task automatic test_reset();
    do_reset();
    sensor_mask = 3'b111;
    for (int i = 0; i < 4; i++) begin
      meas_end = 3'($urandom_range(0, 7));
      step();
    end
    meas_end = 3'b000;
    step();
  endtask

  // Full R/L/M rotation, each channel measuring 40960 -> 20.
  task automatic test_scan_basic();
    int         rises[$];
    logic [2:0] prev_s;
    prev_s      = 3'b000;
    sensor_mask = 3'b111;
    enable      = 1'b1;
    raw_r = 20'd40960; raw_l = 20'd40960; raw_m = 20'd40960;
    step();
    for (int i = 0; i < 3 * SLOT; i++) begin
      meas_end = owner_pulse(20);
      if (start != 3'b000 && prev_s == 3'b000) rises.push_back(cyc);
      prev_s = start;
      step();
    end
    total++; if (rises.size() != 3) begin bad++; $display("FAIL start_rises got=%0d want=3", rises.size()); end
    for (int i = 1; i < rises.size(); i++) begin
      total++;
      if (rises[i] - rises[i-1] != SLOT) begin
        bad++; $display("FAIL start_spacing got=%0d want=%0d", rises[i] - rises[i-1], SLOT);
      end
    end
    total++; if ({dist_r, dist_l, dist_m} !== {8'd20, 8'd20, 8'd20}) begin bad++; $display("FAIL basic_dist got=%0d/%0d/%0d want=20/20/20", dist_r, dist_l, dist_m); end
    total++; if (timeout !== 3'b000) begin bad++; $display("FAIL basic_timeout got=%b want=000", timeout); end
  endtask

  task automatic test_saturation();
    raw_m = 20'hFFFFF;
    for (int i = 0; i < 3 * SLOT; i++) begin
      meas_end = owner_pulse(20);
      step();
    end
    total++; if (dist_m !== 8'd255) begin bad++; $display("FAIL sat_dist_m got=%0d want=255", dist_m); end
    total++; if (timeout[2] !== 1'b0) begin bad++; $display("FAIL sat_timeout_m got=%b want=0", timeout[2]); end
    total++; if (dist_r !== 8'd20) begin bad++; $display("FAIL sat_dist_r got=%0d want=20", dist_r); end
  endtask

  task automatic test_timeout();
    raw_l = 20'd22528;
    for (int i = 0; i < 2 * SLOT; i++) begin
      meas_end = (m_ch == 1) ? 3'b000 : owner_pulse(20);
      step();
    end
    // First cycle of the M slot: the L slot end strobe is visible now.
    total++; if (dist_vld !== 3'b010) begin bad++; $display("FAIL to_vld got=%b want=010", dist_vld); end
    total++; if (dist_l !== 8'd255) begin bad++; $display("FAIL to_dist_l got=%0d want=255", dist_l); end
    total++; if (timeout !== 3'b010) begin bad++; $display("FAIL to_flag got=%b want=010", timeout); end
    for (int i = 0; i < 3 * SLOT; i++) begin
      meas_end = owner_pulse(20);
      step();
    end
    total++; if (dist_l !== 8'd11) begin bad++; $display("FAIL to_recover_dist got=%0d want=11", dist_l); end
    total++; if (timeout[1] !== 1'b0) begin bad++; $display("FAIL to_recover_flag got=%b want=0", timeout[1]); end
    for (int i = 0; i < SLOT; i++) begin
      meas_end = owner_pulse(20);
      step();
    end
  endtask

  // Mask 101: R, M, R, M. Owner edges during TRIG and second edges in a slot
  // must be ignored, and so must everything on meas_end[1].
  task automatic test_mask();
    int seq[$];
    int want[4] = '{0, 2, 0, 2};
    sensor_mask = 3'b101;
    for (int i = 0; i < 4 * SLOT; i++) begin
      logic [2:0] me;
      if (i % SLOT == 0) seq.push_back(int'(cur_ch));
      me = 3'b000;
      if (m_active && ((m_pos >= 1 && m_pos <= 2) || (m_pos >= 30 && m_pos < 35) || (m_pos >= 50 && m_pos < 55)))
        me = bit_of(m_ch);
      if ((m_pos >= 10 && m_pos < 16) || (m_pos >= 60 && m_pos < 66)) me[1] = 1'b1;
      meas_end = me;
      raw_r = (m_pos < 45) ? 20'd20480 : 20'd202752;
      raw_m = (m_pos < 45) ? 20'd20480 : 20'd202752;
      raw_l = 20'd202752;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i < seq.size() && seq[i] != want[i]) begin bad++; $display("FAIL mask_seq[%0d] got=%0d want=%0d", i, seq[i], want[i]); end
      else if (i >= seq.size()) begin bad++; $display("FAIL mask_seq[%0d] got=none want=%0d", i, want[i]); end
    end
    total++; if ({dist_r, dist_l, dist_m} !== {8'd10, 8'd11, 8'd10}) begin bad++; $display("FAIL mask_dist got=%0d/%0d/%0d want=10/11/10", dist_r, dist_l, dist_m); end
  endtask

  // enable drops mid L slot; the slot completes and captures, then idles and
  // resumes at M.
  task automatic test_enable_drop();
    sensor_mask = 3'b111;
    raw_r = 20'd40960;
    raw_l = 20'd61440;
    raw_m = 20'd40960;
    for (int i = 0; i < SLOT; i++) begin
      meas_end = owner_pulse(20);
      step();
    end
    for (int i = 0; i < SLOT; i++) begin
      if (m_pos == 30) enable = 1'b0;
      meas_end = owner_pulse(50);
      step();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy); end
    total++; if (cur_ch !== 2'd3) begin bad++; $display("FAIL drop_cur_ch got=%0d want=3", cur_ch); end
    total++; if (dist_l !== 8'd30) begin bad++; $display("FAIL drop_dist_l got=%0d want=30", dist_l); end
    meas_end = 3'b000;
    repeat (10) step();
    enable = 1'b1;
    step();
    total++; if (cur_ch !== 2'd2) begin bad++; $display("FAIL resume_ch got=%0d want=2", cur_ch); end
    for (int i = 0; i < SLOT; i++) begin
      meas_end = owner_pulse(20);
      step();
    end
  endtask

  // Reset on the fourth cycle of an R start pulse, then restart at R.
  task automatic test_reset_mid();
    meas_end = 3'b000;
    repeat (3) step();
    total++; if (start !== 3'b001) begin bad++; $display("FAIL pre_rst_start got=%b want=001", start); end
    do_reset();
    sensor_mask = 3'b110;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b want=0", busy); end
    sensor_mask = 3'b111;
    enable = 1'b1;
    step();
    total++; if (cur_ch !== 2'd0) begin bad++; $display("FAIL post_rst_ch got=%0d want=0", cur_ch); end
    for (int i = 0; i < SLOT; i++) begin
      meas_end = owner_pulse(20);
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        sensor_mask = 3'($urandom_range(0, 7));
        enable      = ($urandom_range(0, 7) != 0);
      end
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 11) == 0) meas_end[b] = ~meas_end[b];
      raw_r = RAW_W'($urandom_range(0, (1 << RAW_W) - 1));
      raw_l = RAW_W'($urandom_range(0, (1 << RAW_W) - 1));
      raw_m = RAW_W'($urandom_range(0, (1 << RAW_W) - 1));
      step();
    end
    enable = 1'b0;
    for (int i = 0; i < SLOT + 5; i++) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_drain_busy got=%b want=0", busy); end
  endtask

  initial begin
    #2;
    test_reset();
    test_scan_basic();
    test_saturation();
    test_timeout();
    test_mask();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
